demux2_stream: RTL and testbench

Streaming 1-to-2 demultiplexer: steers each accepted input word to one of two output channels and buffers it in a per-channel FIFO with valid/ready handshakes. It is the distribution counterpart of the 2:1 word multiplexers in the datapath. It sits between the accumulator result path and two downstream consumers, such as writeback and the next layer's input staging. Each output channel drains independently, so one stalled consumer does not block traffic already buffered for the other.

---
 rtl/demux2_stream.sv | 111 +++++++++++
 tb/tb_demux2_stream.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux2_stream.sv
// rtl/demux2_stream.sv - streaming 1-to-2 demultiplexer with a FIFO on each output channel
// Optional DEMUX2_PINGPONG_EN: alternate destinations 0,1,0,1 and ignore in_sel.
module demux2_stream #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_sel,
  output logic                     out0_valid,
  input  logic                     out0_ready,
  output logic [WIDTH-1:0]         out0_data,
  output logic                     out1_valid,
  input  logic                     out1_ready,
  output logic [WIDTH-1:0]         out1_data,
  output logic [$clog2(DEPTH):0]   out0_count,
  output logic [$clog2(DEPTH):0]   out1_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic             dst;
  logic             accept;
  logic [1:0]       push;
  logic [1:0]       pop;
  logic [1:0]       full;
  logic [1:0]       valid;
  logic [CW-1:0]    cnt    [2];
  logic [AW-1:0]    wr_ptr [2];
  logic [AW-1:0]    rd_ptr [2];
  logic [WIDTH-1:0] mem    [2][DEPTH];

`ifdef DEMUX2_PINGPONG_EN
  logic pp_ptr;
  logic unused_sel;

  assign unused_sel = in_sel;
  assign dst        = pp_ptr;

  // Pointer only moves on an accepted word, so a full target stalls it in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pp_ptr <= 1'b0;
    end else if (accept) begin
      pp_ptr <= ~pp_ptr;
    end
  end
`else
  assign dst = in_sel;
`endif

  always_comb begin
    full[0]  = (cnt[0] == FULL);
    full[1]  = (cnt[1] == FULL);
    valid[0] = (cnt[0] != '0);
    valid[1] = (cnt[1] != '0);
  end

  // Registered occupancy only: a same-cycle pop never opens in_ready.
  assign in_ready = ~full[dst];
  assign accept   = in_valid & in_ready;

  always_comb begin
    push = 2'b00;
    if (accept) begin
      push[dst] = 1'b1;
    end
    pop = valid & {out1_ready, out0_ready};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < 2; c++) begin
        cnt[c]    <= '0;
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
        for (int i = 0; i < DEPTH; i++) begin
          mem[c][i] <= '0;
        end
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (push[c]) begin
          mem[c][wr_ptr[c]] <= in_data;
          wr_ptr[c]         <= wr_ptr[c] + 1'b1;
        end
        if (pop[c]) begin
          rd_ptr[c] <= rd_ptr[c] + 1'b1;
        end
        case ({push[c], pop[c]})
          2'b10:   cnt[c] <= cnt[c] + 1'b1;
          2'b01:   cnt[c] <= cnt[c] - 1'b1;
          default: cnt[c] <= cnt[c];
        endcase
      end
    end
  end

  assign out0_valid = valid[0];
  assign out1_valid = valid[1];
  assign out0_data  = mem[0][rd_ptr[0]];
  assign out1_data  = mem[1][rd_ptr[1]];
  assign out0_count = cnt[0];
  assign out1_count = cnt[1];

endmodule

// File: tb/tb_demux2_stream.sv
// tb/tb_demux2_stream.sv - self-checking bench for demux2_stream (table, directed and random vs queue model)
module tb_demux2_stream;

  localparam int WIDTH = 34;
  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             out0_valid;
  logic             out0_ready;
  logic [WIDTH-1:0] out0_data;
  logic             out1_valid;
  logic             out1_ready;
  logic [WIDTH-1:0] out1_data;
  logic [CW-1:0]    out0_count;
  logic [CW-1:0]    out1_count;

  demux2_stream #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_data  (out0_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data),
    .out0_count (out0_count),
    .out1_count (out1_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: one queue per channel plus the alternation bit.
  logic [WIDTH-1:0] q0[$];
  logic [WIDTH-1:0] q1[$];
  logic             pp;
  logic             last_acc;

  typedef struct {
    logic             v;
    logic             sel;
    logic             r0;
    logic             r1;
    logic [WIDTH-1:0] d;
    logic             e_rdy;
    logic             e_v0;
    logic             e_v1;
    logic [CW-1:0]    e_c0;
    logic [CW-1:0]    e_c1;
    logic [WIDTH-1:0] e_d0;
    logic [WIDTH-1:0] e_d1;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic model_dst();
`ifdef DEMUX2_PINGPONG_EN
    return pp;
`else
    return in_sel;
`endif
  endfunction

  task automatic model_clear();
    q0.delete();
    q1.delete();
    pp = 1'b0;
  endtask

  // Called at a negedge with inputs already driven; checks, then advances one cycle.
  task automatic step();
    logic e_rdy;
    logic p0;
    logic p1;
    #1;
    e_rdy = model_dst() ? (q1.size() != DEPTH) : (q0.size() != DEPTH);
    chk("in_ready", 64'(in_ready), 64'(e_rdy));
    chk("out0_valid", 64'(out0_valid), 64'(q0.size() != 0));
    chk("out1_valid", 64'(out1_valid), 64'(q1.size() != 0));
    chk("out0_count", 64'(out0_count), 64'(q0.size()));
    chk("out1_count", 64'(out1_count), 64'(q1.size()));
    if (q0.size() != 0) chk("out0_data", 64'(out0_data), 64'(q0[0]));
    if (q1.size() != 0) chk("out1_data", 64'(out1_data), 64'(q1[0]));
    last_acc = in_valid & e_rdy;
    p0 = (q0.size() != 0) & out0_ready;
    p1 = (q1.size() != 0) & out1_ready;
    @(posedge clk);
    if (p0) void'(q0.pop_front());
    if (p1) void'(q1.pop_front());
    if (last_acc) begin
      if (model_dst()) q1.push_back(in_data);
      else             q0.push_back(in_data);
      pp = ~pp;
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic s, input logic [WIDTH-1:0] d,
                       input logic r0, input logic r1);
    in_valid   = v;
    in_sel     = s;
    in_data    = d;
    out0_ready = r0;
    out1_ready = r1;
  endtask

  task automatic run_random(input int words, input string name);
    int   acc  = 0;
    int   cyc  = 0;
    logic hold = 1'b0;
    while (acc < words && cyc < 20000) begin
      if (!hold) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_sel   = 1'($urandom_range(0, 1));
        in_data  = WIDTH'({$urandom(), $urandom()});
      end
      out0_ready = ($urandom_range(0, 2) != 0);
      out1_ready = ($urandom_range(0, 2) != 0);
      step();
      if (last_acc) acc++;
      hold = in_valid && !last_acc;
      cyc++;
    end
    chk(name, 64'(acc), 64'(words));
  endtask

  localparam logic [WIDTH-1:0] WA = 34'h2_AAAA_0001;
  localparam logic [WIDTH-1:0] WB = 34'h1_5555_0002;
  localparam logic [WIDTH-1:0] WC = 34'h3_0F0F_0003;
  localparam logic [WIDTH-1:0] WD = 34'h0_1234_5678;

  vec_t vec [9];

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    model_clear();
    last_acc = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out0_valid", 64'(out0_valid), 64'd0);
    chk("rst_out1_valid", 64'(out1_valid), 64'd0);
    chk("rst_out0_data", 64'(out0_data), 64'd0);
    chk("rst_out1_data", 64'(out1_data), 64'd0);
    chk("rst_out0_count", 64'(out0_count), 64'd0);
    chk("rst_out1_count", 64'(out1_count), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic steering with both consumers ready.
    drive(1'b1, 1'b0, 34'h3_0000_0001, 1'b1, 1'b1);
    step();
    chk("t1_out0_valid", 64'(out0_valid), 64'd1);
    chk("t1_out0_data", 64'(out0_data), 64'h3_0000_0001);
    drive(1'b1, 1'b1, 34'h0_0000_00AA, 1'b1, 1'b1);
    step();
    chk("t1_out1_valid", 64'(out1_valid), 64'd1);
    chk("t1_out1_data", 64'(out1_data), 64'h0_0000_00AA);
    chk("t1_out0_drained", 64'(out0_valid), 64'd0);
    drive(1'b0, 1'b0, '0, 1'b1, 1'b1);
    step();
    chk("t1_count0", 64'(out0_count), 64'd0);
    chk("t1_count1", 64'(out1_count), 64'd0);

`ifndef DEMUX2_PINGPONG_EN
    // Fill channel 0, side push on channel 1, then full-with-pop refusal.
    vec[0] = '{1'b1, 1'b0, 1'b0, 1'b0, WA, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, '0, '0};
    vec[1] = '{1'b1, 1'b0, 1'b0, 1'b0, WB, 1'b1, 1'b1, 1'b0, 2'd1, 2'd0, WA, '0};
    vec[2] = '{1'b1, 1'b0, 1'b0, 1'b0, WC, 1'b0, 1'b1, 1'b0, 2'd2, 2'd0, WA, '0};
    vec[3] = '{1'b1, 1'b1, 1'b0, 1'b0, WD, 1'b1, 1'b1, 1'b0, 2'd2, 2'd0, WA, '0};
    vec[4] = '{1'b1, 1'b0, 1'b1, 1'b1, WC, 1'b0, 1'b1, 1'b1, 2'd2, 2'd1, WA, WD};
    vec[5] = '{1'b1, 1'b0, 1'b0, 1'b0, WC, 1'b1, 1'b1, 1'b0, 2'd1, 2'd0, WB, '0};
    vec[6] = '{1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0, 2'd2, 2'd0, WB, '0};
    vec[7] = '{1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b1, 1'b1, 1'b0, 2'd1, 2'd0, WC, '0};
    vec[8] = '{1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, '0, '0};
    for (int i = 0; i < 9; i++) begin
      drive(vec[i].v, vec[i].sel, vec[i].d, vec[i].r0, vec[i].r1);
      #1;
      chk($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'(vec[i].e_rdy));
      chk($sformatf("vec%0d_out0_valid", i), 64'(out0_valid), 64'(vec[i].e_v0));
      chk($sformatf("vec%0d_out1_valid", i), 64'(out1_valid), 64'(vec[i].e_v1));
      chk($sformatf("vec%0d_count0", i), 64'(out0_count), 64'(vec[i].e_c0));
      chk($sformatf("vec%0d_count1", i), 64'(out1_count), 64'(vec[i].e_c1));
      if (vec[i].e_v0) chk($sformatf("vec%0d_out0_data", i), 64'(out0_data), 64'(vec[i].e_d0));
      if (vec[i].e_v1) chk($sformatf("vec%0d_out1_data", i), 64'(out1_data), 64'(vec[i].e_d1));
      @(posedge clk);
      @(negedge clk);
    end
`endif

    run_random(1000, "random_words");

    // Fill both channels, then reset asynchronously mid-cycle.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'(i), WIDTH'(34'h1_0000_0000 + i), 1'b0, 1'b0);
      step();
    end
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    step();
    chk("pre_rst_count0", 64'(out0_count), 64'(DEPTH));
    chk("pre_rst_count1", 64'(out1_count), 64'(DEPTH));
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out0_valid", 64'(out0_valid), 64'd0);
    chk("mid_rst_out1_valid", 64'(out1_valid), 64'd0);
    chk("mid_rst_count0", 64'(out0_count), 64'd0);
    chk("mid_rst_count1", 64'(out1_count), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    run_random(100, "post_rst_words");

`ifdef DEMUX2_PINGPONG_EN
    // Alternation with in_sel tied high; out1 held full stalls the pointer on 1.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    for (int w = 1; w <= 5; w++) begin
      drive(1'b1, 1'b1, WIDTH'(w), 1'b1, 1'b0);
      step();
      chk($sformatf("pp_word%0d_acc", w), 64'(last_acc), 64'd1);
    end
    drive(1'b1, 1'b1, WIDTH'(6), 1'b1, 1'b0);
    step();
    chk("pp_stall_refused", 64'(last_acc), 64'd0);
    chk("pp_out1_head", 64'(out1_data), 64'd2);
    chk("pp_out1_count", 64'(out1_count), 64'd2);
    step();
    chk("pp_stall_hold", 64'(last_acc), 64'd0);
    drive(1'b1, 1'b1, WIDTH'(6), 1'b1, 1'b1);
    step();
    chk("pp_pop_no_bypass", 64'(last_acc), 64'd0);
    step();
    chk("pp_word6_acc", 64'(last_acc), 64'd1);
    chk("pp_out1_head_next", 64'(out1_data), 64'd6);
`endif

    drive(1'b0, 1'b0, '0, 1'b1, 1'b1);
    repeat (DEPTH + 1) step();
    chk("final_count0", 64'(out0_count), 64'd0);
    chk("final_count1", 64'(out1_count), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
